// File: rtl/pattern_detector_pkg.sv
// rtl/pattern_detector_pkg.sv - shared state encoding and parameter limits for pattern_detector
package pattern_detector_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    FILL   = 2'd2,
    DETECT = 2'd3
  } state_e;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;
  localparam int CNT_W_MIN = 1;
  localparam int CNT_W_MAX = 16;

endpackage

// File: rtl/sipo_shreg.sv
// rtl/sipo_shreg.sv - serial-in parallel-out shift register, new bit enters bit 0
module sipo_shreg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_d, q_q;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (en) begin
      q_d = {q_q[WIDTH-2:0], din};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/pattern_detector.sv
// rtl/pattern_detector.sv - serial-programmed overlapping pattern detector with saturating match count
// Optional don't-care mask via PATTERN_DETECTOR_MASK_EN (adds mask_bit port and msk register).
module pattern_detector
  import pattern_detector_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig,
  input  logic             prgm,
`ifdef PATTERN_DETECTOR_MASK_EN
  input  logic             mask_bit,
`endif
  output logic             out,
  output logic             armed,
  output logic [CNT_W-1:0] match_count
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]    FULL    = CW'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_d, state_q;
  logic [CW-1:0]    load_cnt_d, load_cnt_q;
  logic [CW-1:0]    fill_cnt_d, fill_cnt_q;
  logic             out_d, out_q;
  logic             armed_d, armed_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  logic [WIDTH-1:0] pat, sreg, sreg_next, diff;
  logic             sreg_en, hit;

  // The stream register also takes the falling-prgm bit as the first stream bit.
  assign sreg_en = !prgm && ((state_q == FILL) || (state_q == DETECT) ||
                             ((state_q == LOAD) && (load_cnt_q == FULL)));

  sipo_shreg #(.WIDTH(WIDTH)) u_pat (
    .clk(clk), .rst_n(rst_n), .clr(1'b0), .en(prgm), .din(sig), .q(pat)
  );

  sipo_shreg #(.WIDTH(WIDTH)) u_sreg (
    .clk(clk), .rst_n(rst_n), .clr(prgm), .en(sreg_en), .din(sig), .q(sreg)
  );

  assign sreg_next = {sreg[WIDTH-2:0], sig};

`ifdef PATTERN_DETECTOR_MASK_EN
  logic [WIDTH-1:0] msk;

  sipo_shreg #(.WIDTH(WIDTH)) u_msk (
    .clk(clk), .rst_n(rst_n), .clr(1'b0), .en(prgm), .din(mask_bit), .q(msk)
  );

  assign diff = (sreg_next ^ pat) & ~msk;
`else
  assign diff = sreg_next ^ pat;
`endif

  assign hit = (diff == '0);

  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    fill_cnt_d = fill_cnt_q;
    out_d      = 1'b0;
    armed_d    = armed_q;
    cnt_d      = cnt_q;
    if (prgm) begin
      state_d    = LOAD;
      fill_cnt_d = '0;
      armed_d    = 1'b0;
      if (state_q != LOAD) begin
        load_cnt_d = CW'(1);
        cnt_d      = '0;
      end else if (load_cnt_q != FULL) begin
        load_cnt_d = load_cnt_q + CW'(1);
      end
    end else begin
      case (state_q)
        LOAD: begin
          if (load_cnt_q == FULL) begin
            state_d    = FILL;
            fill_cnt_d = CW'(1);
            armed_d    = 1'b1;
          end else begin
            state_d = IDLE;
            armed_d = 1'b0;
          end
        end
        FILL, DETECT: begin
          if (fill_cnt_q != FULL) begin
            fill_cnt_d = fill_cnt_q + CW'(1);
          end
          if (fill_cnt_d == FULL) begin
            state_d = DETECT;
          end
          out_d = hit && (fill_cnt_d == FULL);
          if (out_d && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      load_cnt_q <= '0;
      fill_cnt_q <= '0;
      out_q      <= 1'b0;
      armed_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      fill_cnt_q <= fill_cnt_d;
      out_q      <= out_d;
      armed_q    <= armed_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out         = out_q;
  assign armed       = armed_q;
  assign match_count = cnt_q;

endmodule

// File: tb/tb_pattern_detector.sv
// tb/tb_pattern_detector.sv - self-checking bench: vector table, corner sequences, random vs queue model
module tb_pattern_detector;

  localparam int W      = 4;
  localparam int CNTW   = 8;
  localparam int CNTMAX = (1 << CNTW) - 1;

  logic            clk;
  logic            rst_n;
  logic            sig;
  logic            prgm;
  logic            mask_v;
  logic            out;
  logic            armed;
  logic [CNTW-1:0] match_count;

  int n_checks;
  int n_errors;

  pattern_detector #(.WIDTH(W), .CNT_W(CNTW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sig        (sig),
    .prgm       (prgm),
`ifdef PATTERN_DETECTOR_MASK_EN
    .mask_bit   (mask_v),
`endif
    .out        (out),
    .armed      (armed),
    .match_count(match_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: remembers the programmed bits and the stream since arming.
  bit          m_prog[$];
  bit          m_msk[$];
  bit          m_stream[$];
  int unsigned m_load_n;
  bit          m_in_prog;
  bit          m_armed;
  bit          m_out;
  int unsigned m_cnt;

  function automatic void model_reset();
    m_prog.delete();
    m_msk.delete();
    m_stream.delete();
    m_load_n  = 0;
    m_in_prog = 0;
    m_armed   = 0;
    m_out     = 0;
    m_cnt     = 0;
  endfunction

  function automatic void model_edge(input bit p, input bit s, input bit mb);
    bit h;
    m_out = 0;
    if (p) begin
      if (!m_in_prog) begin
        m_prog.delete();
        m_msk.delete();
        m_load_n = 0;
        m_cnt    = 0;
      end
      m_in_prog = 1;
      m_armed   = 0;
      m_stream.delete();
      m_prog.push_back(s);
`ifdef PATTERN_DETECTOR_MASK_EN
      m_msk.push_back(mb);
`else
      m_msk.push_back(1'b0 & mb);
`endif
      m_load_n++;
      if (m_prog.size() > W) begin
        void'(m_prog.pop_front());
        void'(m_msk.pop_front());
      end
    end else begin
      if (m_in_prog) begin
        m_in_prog = 0;
        m_armed   = (m_load_n >= W);
      end
      if (m_armed) begin
        m_stream.push_back(s);
        if (m_stream.size() > W) void'(m_stream.pop_front());
        if (m_stream.size() == W) begin
          h = 1;
          for (int i = 0; i < W; i++)
            if (!m_msk[i] && (m_stream[i] != m_prog[i])) h = 0;
          m_out = h;
        end
        if (m_out && (m_cnt < CNTMAX)) m_cnt++;
      end
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic p, input logic s, input logic mb);
    @(negedge clk);
    prgm   = p;
    sig    = s;
    mask_v = mb;
    @(posedge clk);
    model_edge(p, s, mask_v);
    #1;
    check("model_out", 32'(out), 32'(m_out));
    check("model_armed", 32'(armed), 32'(m_armed));
    check("model_count", 32'(match_count), m_cnt);
  endtask

  // Sends n bits MSB first, with matching mask bits.
  task automatic send_bits(input logic p, input logic [31:0] bits, input int n, input logic [31:0] mbits);
    for (int i = n - 1; i >= 0; i--) step(p, bits[i], mbits[i]);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst_n = 1'b0;
    prgm  = 1'($urandom);
    sig   = 1'($urandom);
    model_reset();
    #1;
    check("rst_out_async", 32'(out), 32'd0);
    check("rst_armed_async", 32'(armed), 32'd0);
    check("rst_count_async", 32'(match_count), 32'd0);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      prgm = 1'($urandom);
      sig  = 1'($urandom);
      @(posedge clk);
      #1;
      check("rst_out_hold", 32'(out), 32'd0);
      check("rst_armed_hold", 32'(armed), 32'd0);
      check("rst_count_hold", 32'(match_count), 32'd0);
    end
    @(negedge clk);
    prgm = 1'b0;
    sig  = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  typedef struct {
    logic       prgm;
    logic       sig;
    logic       exp_out;
    logic       exp_armed;
    logic [7:0] exp_cnt;
  } vec_t;

  vec_t tbl[12];
  logic rp;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    prgm     = 1'b0;
    sig      = 1'b0;
    mask_v   = 1'b0;
    model_reset();

    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'd0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'd0};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'd1};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd1};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'd1};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'd2};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd2};

    do_reset(3);
    step(1'b0, 1'b1, 1'b0);
    check("post_reset_out", 32'(out), 32'd0);

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].prgm, tbl[i].sig, 1'b0);
      check($sformatf("tbl%0d_out", i), 32'(out), 32'(tbl[i].exp_out));
      check($sformatf("tbl%0d_armed", i), 32'(armed), 32'(tbl[i].exp_armed));
      check($sformatf("tbl%0d_count", i), 32'(match_count), 32'(tbl[i].exp_cnt));
    end

    send_bits(1'b1, 32'b101, 3, 32'd0);
    for (int r = 0; r < 3; r++) send_bits(1'b0, 32'b1011, 4, 32'd0);
    check("short_armed", 32'(armed), 32'd0);
    check("short_count", 32'(match_count), 32'd0);

    send_bits(1'b1, 32'b001101, 6, 32'd0);
    send_bits(1'b0, 32'b1101, 4, 32'd0);
    check("long_hit_out", 32'(out), 32'd1);
    check("long_hit_count", 32'(match_count), 32'd1);
    send_bits(1'b0, 32'b0011, 4, 32'd0);
    check("long_miss_out", 32'(out), 32'd0);
    check("long_miss_count", 32'(match_count), 32'd1);

    send_bits(1'b1, 32'b1111, 4, 32'd0);
    for (int i = 0; i < 270; i++) step(1'b0, 1'b1, 1'b0);
    check("sat_out", 32'(out), 32'd1);
    check("sat_count", 32'(match_count), 32'(CNTMAX));
    step(1'b1, 1'b1, 1'b0);
    check("abort_out", 32'(out), 32'd0);
    check("abort_count", 32'(match_count), 32'd0);
    check("abort_armed", 32'(armed), 32'd0);

`ifdef PATTERN_DETECTOR_MASK_EN
    send_bits(1'b1, 32'b1011, 4, 32'b0100);
    send_bits(1'b0, 32'b1011, 4, 32'd0);
    check("mask_1011_count", 32'(match_count), 32'd1);
    send_bits(1'b1, 32'b1011, 4, 32'b0100);
    send_bits(1'b0, 32'b1111, 4, 32'd0);
    check("mask_1111_count", 32'(match_count), 32'd1);
    send_bits(1'b1, 32'b1011, 4, 32'b0100);
    send_bits(1'b0, 32'b0011, 4, 32'd0);
    check("mask_0011_count", 32'(match_count), 32'd0);
`endif

    rp = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (rp) rp = ($urandom_range(9) < 7);
      else    rp = ($urandom_range(99) < 4);
      if ($urandom_range(499) == 0) do_reset(1);
      step(rp, 1'($urandom), 1'($urandom_range(3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
